hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 95 +++++++++
 tb/tb_hazard_scoreboard.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Load-use / RAW hazard tracker for a 5-stage pipeline: shadows the EXE and MEM
// destinations, raises a stall when an ID source collides with a pending write.
module hazard_scoreboard #(
  parameter int unsigned ADDRESS_LEN_REG_FILE = 4,
  parameter int unsigned STALL_CNT_LEN        = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ID_WB_EN,
  input  logic                            ID_MEM_R_EN,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] ID_Dest,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] Hazard_src1,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] Hazard_src2,
  input  logic                            Two_src,
  input  logic                            Forward_EN,
  input  logic                            Flush,
  input  logic                            Freeze,
  output logic                            Hazard,
  output logic [ADDRESS_LEN_REG_FILE-1:0] EXE_busy_dest,
  output logic [ADDRESS_LEN_REG_FILE-1:0] MEM_busy_dest,
  output logic [STALL_CNT_LEN-1:0]        Stall_count
);

  typedef struct packed {
    logic                            wb;
    logic                            ld;
    logic [ADDRESS_LEN_REG_FILE-1:0] dest;
  } slot_t;

  localparam logic [STALL_CNT_LEN-1:0] CntMax = '1;

  slot_t                     exe_q, exe_d;
  slot_t                     mem_q, mem_d;
  logic [STALL_CNT_LEN-1:0]  cnt_q, cnt_d;

  logic exe_hit, mem_hit;

  // src2 only participates when the instruction really reads it.
  always_comb begin
    exe_hit = exe_q.wb && ((exe_q.dest == Hazard_src1) ||
                           (Two_src && (exe_q.dest == Hazard_src2)));
    mem_hit = mem_q.wb && ((mem_q.dest == Hazard_src1) ||
                           (Two_src && (mem_q.dest == Hazard_src2)));
  end

  // With forwarding only a load in EXE cannot be bypassed in time.
  always_comb begin
    Hazard = 1'b0;
    if (!Flush) begin
      if (Forward_EN) begin
        Hazard = exe_q.ld && exe_hit;
      end else begin
        Hazard = exe_hit || mem_hit;
      end
    end
  end

  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (!Freeze) begin
      mem_d = exe_q;
      if (Hazard || Flush) begin
        exe_d = '0;
      end else begin
        exe_d.wb   = ID_WB_EN;
        exe_d.ld   = ID_MEM_R_EN;
        exe_d.dest = ID_Dest;
      end
      if (Hazard && (cnt_q != CntMax)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q <= '0;
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    EXE_busy_dest = exe_q.wb ? exe_q.dest : '0;
    MEM_busy_dest = mem_q.wb ? mem_q.dest : '0;
    Stall_count   = cnt_q;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table-driven bench for hazard_scoreboard, plus a saturation sequence
// on a narrow-counter instance.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, wb_en, mem_r_en, two_src, fwd_en, flush, freeze;
  logic [3:0] id_dest, src1, src2;

  logic        hz, hz_s;
  logic [3:0]  exe_bd, mem_bd, exe_s, mem_s;
  logic [15:0] cnt;
  logic [3:0]  cnt_s;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .ID_WB_EN(wb_en), .ID_MEM_R_EN(mem_r_en), .ID_Dest(id_dest),
    .Hazard_src1(src1), .Hazard_src2(src2), .Two_src(two_src), .Forward_EN(fwd_en),
    .Flush(flush), .Freeze(freeze), .Hazard(hz), .EXE_busy_dest(exe_bd),
    .MEM_busy_dest(mem_bd), .Stall_count(cnt)
  );

  hazard_scoreboard #(.ADDRESS_LEN_REG_FILE(4), .STALL_CNT_LEN(4)) dut_sat (
    .clk(clk), .rst(rst), .ID_WB_EN(wb_en), .ID_MEM_R_EN(mem_r_en), .ID_Dest(id_dest),
    .Hazard_src1(src1), .Hazard_src2(src2), .Two_src(two_src), .Forward_EN(fwd_en),
    .Flush(flush), .Freeze(freeze), .Hazard(hz_s), .EXE_busy_dest(exe_s),
    .MEM_busy_dest(mem_s), .Stall_count(cnt_s)
  );

  typedef struct {
    logic        rst, wb, ld;
    logic [3:0]  dest, s1, s2;
    logic        two, fwd, fl, fz;
    logic        hz;
    logic [3:0]  exe, mem;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic r, w, l, input logic [3:0] d, a, b,
                     input logic t, f, fl, fz, h, input logic [3:0] e, m,
                     input logic [15:0] c);
    vec_t v;
    v.rst = r; v.wb = w; v.ld = l; v.dest = d; v.s1 = a; v.s2 = b;
    v.two = t; v.fwd = f; v.fl = fl; v.fz = fz; v.hz = h;
    v.exe = e; v.mem = m; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; wb_en = v.wb; mem_r_en = v.ld; id_dest = v.dest;
    src1 = v.s1; src2 = v.s2; two_src = v.two; fwd_en = v.fwd;
    flush = v.fl; freeze = v.fz;
  endtask

  initial begin
    //   rst wb ld dest s1 s2 two fwd fl fz | hz exe mem cnt
    add(1, 1, 0, 9,  0, 0,  0, 0, 1, 1,   0, 0,  0,  0);  // rst beats freeze/flush
    add(0, 1, 0, 3,  0, 0,  0, 0, 0, 0,   0, 3,  0,  0);  // RAW, no forwarding
    add(0, 1, 0, 6,  3, 0,  0, 0, 0, 0,   1, 0,  3,  1);
    add(0, 1, 0, 6,  3, 0,  0, 0, 0, 0,   1, 0,  0,  2);
    add(0, 1, 0, 6,  3, 0,  0, 0, 0, 0,   0, 6,  0,  2);
    add(0, 1, 1, 5,  0, 0,  0, 1, 0, 0,   0, 5,  6,  2);  // load-use via src2
    add(0, 1, 0, 8,  1, 5,  1, 1, 0, 0,   1, 0,  5,  3);
    add(0, 1, 0, 8,  1, 5,  1, 1, 0, 0,   0, 8,  0,  3);
    add(0, 1, 1, 5,  0, 0,  0, 1, 0, 0,   0, 5,  8,  3);  // src2 unqualified
    add(0, 0, 0, 0,  1, 5,  0, 1, 0, 0,   0, 0,  5,  3);
    add(0, 1, 0, 7,  0, 0,  0, 1, 0, 0,   0, 7,  0,  3);  // non-load forwarded
    add(0, 1, 0, 7,  7, 0,  0, 1, 0, 0,   0, 7,  7,  3);
    add(0, 0, 0, 0,  0, 7,  1, 0, 0, 0,   1, 0,  7,  4);  // src2 vs EXE, no fwd
    add(0, 0, 0, 0,  0, 7,  1, 0, 0, 0,   1, 0,  0,  5);
    add(0, 1, 0, 2,  0, 0,  0, 0, 0, 0,   0, 2,  0,  5);  // stall under freeze
    add(0, 1, 0, 9,  2, 0,  0, 0, 0, 1,   1, 2,  0,  5);
    add(0, 1, 0, 9,  2, 0,  0, 0, 0, 1,   1, 2,  0,  5);
    add(0, 1, 0, 9,  2, 0,  0, 0, 0, 1,   1, 2,  0,  5);
    add(0, 1, 0, 9,  2, 0,  0, 0, 0, 0,   1, 0,  2,  6);
    add(0, 1, 0, 9,  2, 0,  0, 0, 0, 0,   1, 0,  0,  7);
    add(0, 1, 0, 9,  2, 0,  0, 0, 0, 0,   0, 9,  0,  7);
    add(0, 1, 0, 4,  9, 0,  0, 0, 1, 1,   0, 9,  0,  7);  // freeze beats flush
    add(0, 1, 0, 4,  9, 0,  0, 0, 1, 0,   0, 0,  9,  7);  // flush bubbles
    add(0, 1, 0, 4,  9, 0,  0, 0, 1, 0,   0, 0,  0,  7);
    add(0, 1, 0, 15, 0, 0,  0, 0, 0, 0,   0, 15, 0,  7);  // r15 tracked
    add(0, 0, 0, 0,  0, 15, 1, 0, 0, 0,   1, 0,  15, 8);
    add(1, 0, 0, 0,  0, 15, 1, 0, 0, 0,   1, 0,  0,  0);  // reset mid-stall
    add(0, 1, 0, 3,  0, 15, 1, 0, 0, 0,   0, 3,  0,  0);

    rst = 1'b1; wb_en = 1'b0; mem_r_en = 1'b0; id_dest = '0; src1 = '0; src2 = '0;
    two_src = 1'b0; fwd_en = 1'b0; flush = 1'b0; freeze = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      check("hazard", i, 32'(hz), 32'(vecs[i].hz));
      @(posedge clk);
      #1;
      check("exe_busy", i, 32'(exe_bd), 32'(vecs[i].exe));
      check("mem_busy", i, 32'(mem_bd), 32'(vecs[i].mem));
      check("stall_cnt", i, 32'(cnt), 32'(vecs[i].cnt));
    end

    // Back-to-back dependent writes: 2 stall cycles out of every 3.
    rst = 1'b1; wb_en = 1'b0; src1 = '0; src2 = '0; two_src = 1'b0;
    fwd_en = 1'b0; flush = 1'b0; freeze = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0; wb_en = 1'b1; id_dest = 4'd1; src1 = 4'd1;
    repeat (30) @(posedge clk);
    #1;
    check("sat_cnt", 0, 32'(cnt_s), 32'hF);
    check("wide_cnt", 0, 32'(cnt), 32'd20);
    repeat (6) @(posedge clk);
    #1;
    check("sat_hold", 0, 32'(cnt_s), 32'hF);

    rst = 1'b1;
    @(posedge clk);
    #1;
    check("sat_rst_cnt", 0, 32'(cnt_s), 32'd0);
    check("sat_rst_exe", 0, 32'(exe_s), 32'd0);
    check("sat_rst_mem", 0, 32'(mem_s), 32'd0);
    check("sat_rst_hz", 0, 32'(hz_s), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
